// File: rtl/decode_stage_p_if.sv
// Decode-stage bus: decode controls, pipeline result tags, register-file write
// port, and the redirect / ID-EX register outputs.
// master: instruction fetch/control side (drives inputs, observes outputs)
// slave : decode_stage_p
interface decode_stage_p_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 16
);
  logic              stall;
  logic              flush;
  logic [15:0]       instr;
  logic              instr_valid;
  logic [PC_W-1:0]   next_pc;
  logic [1:0]        imm_sel;
  logic              zext8;
  logic              op2_imm;
  logic [1:0]        dest_sel;
  logic              link;
  logic              branch;
  logic              jump;
  logic [1:0]        cond;
  logic              base_pc;
  logic              off11;
  logic              ex_wr_en;
  logic [2:0]        ex_wr_addr;
  logic [DATA_W-1:0] ex_wr_data;
  logic              mem_wr_en;
  logic [2:0]        mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              redirect;
  logic [PC_W-1:0]   target;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] op2_q;
  logic [2:0]        dest_q;
  logic              link_q;
  logic [PC_W-1:0]   link_pc_q;
  logic              valid_q;

  modport master (
    output stall, flush, instr, instr_valid, next_pc, imm_sel, zext8, op2_imm,
           dest_sel, link, branch, jump, cond, base_pc, off11,
           ex_wr_en, ex_wr_addr, ex_wr_data, mem_wr_en, mem_wr_addr, mem_wr_data,
           wb_en, wb_addr, wb_data,
    input  redirect, target, rs_q, op2_q, dest_q, link_q, link_pc_q, valid_q
  );

  modport slave (
    input  stall, flush, instr, instr_valid, next_pc, imm_sel, zext8, op2_imm,
           dest_sel, link, branch, jump, cond, base_pc, off11,
           ex_wr_en, ex_wr_addr, ex_wr_data, mem_wr_en, mem_wr_addr, mem_wr_data,
           wb_en, wb_addr, wb_data,
    output redirect, target, rs_q, op2_q, dest_q, link_q, link_pc_q, valid_q
  );
endinterface

// File: rtl/decode_stage_p.sv
// Curveball decode stage: register file with write-through, EX/MEM/WB operand
// forwarding, branch/jump resolution and the ID/EX pipeline register.
// Ports: clk, rst (sync active-high), bus (decode_stage_p_if.slave).
// redirect/target are combinational; all *_q outputs are registered.
module decode_stage_p #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned NREG    = 8,
  parameter bit          R0_ZERO = 1'b0
) (
  input logic            clk,
  input logic            rst,
  decode_stage_p_if.slave bus
);
  localparam int unsigned AW = 3;

  logic [DATA_W-1:0] r_rf [NREG];
  logic [AW-1:0]     w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_base;
  logic [PC_W-1:0]   w_off;
  logic              w_cond_true;
  logic [AW-1:0]     w_dest;
  logic              w_unused;

  logic [DATA_W-1:0] r_rs_q;
  logic [DATA_W-1:0] r_op2_q;
  logic [AW-1:0]     r_dest_q;
  logic              r_link_q;
  logic [PC_W-1:0]   r_link_pc_q;
  logic              r_valid_q;

  assign w_unused = ^bus.instr[15:11];

  // Register file; r0 writes dropped when R0_ZERO
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
    end else if (bus.wb_en && !(R0_ZERO && (bus.wb_addr == '0))) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign w_rd_addr[0] = bus.instr[10:8];
  assign w_rd_addr[1] = bus.instr[7:5];

  // Operand forwarding, youngest producer first
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rd_data[i] = r_rf[w_rd_addr[i]];
      if (R0_ZERO && (w_rd_addr[i] == '0))
        w_rd_data[i] = '0;
      else if (bus.ex_wr_en && (bus.ex_wr_addr == w_rd_addr[i]))
        w_rd_data[i] = bus.ex_wr_data;
      else if (bus.mem_wr_en && (bus.mem_wr_addr == w_rd_addr[i]))
        w_rd_data[i] = bus.mem_wr_data;
      else if (bus.wb_en && (bus.wb_addr == w_rd_addr[i]))
        w_rd_data[i] = bus.wb_data;
    end
  end

  // Immediate generation
  always_comb begin
    w_imm = '0;
    case (bus.imm_sel)
      2'b00:   w_imm = {{(DATA_W-5){bus.instr[4]}}, bus.instr[4:0]};
      2'b01:   w_imm = {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]};
      2'b10:   w_imm = {{(DATA_W-11){bus.instr[10]}}, bus.instr[10:0]};
      default: w_imm = bus.zext8 ? {{(DATA_W-8){1'b0}}, bus.instr[7:0]}
                                 : {{(DATA_W-4){1'b0}}, bus.instr[3:0]};
    endcase
  end

  // Branch condition on forwarded rs
  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      2'b00:   w_cond_true = (w_rd_data[0] == '0);
      2'b01:   w_cond_true = (w_rd_data[0] != '0);
      2'b10:   w_cond_true = w_rd_data[0][DATA_W-1];
      default: w_cond_true = ~w_rd_data[0][DATA_W-1];
    endcase
  end

  assign w_base = bus.base_pc ? bus.next_pc : w_rd_data[0][PC_W-1:0];
  assign w_off  = bus.off11 ? {{(PC_W-11){bus.instr[10]}}, bus.instr[10:0]}
                            : {{(PC_W-8){bus.instr[7]}}, bus.instr[7:0]};

  assign bus.target   = w_base + w_off;
  assign bus.redirect = bus.instr_valid & ~bus.stall & ~bus.flush & ~rst &
                        (bus.jump | (bus.branch & w_cond_true));

  // Destination select
  always_comb begin
    w_dest = '0;
    case (bus.dest_sel)
      2'b00:   w_dest = bus.instr[7:5];
      2'b01:   w_dest = bus.instr[4:2];
      2'b10:   w_dest = bus.instr[10:8];
      default: w_dest = AW'(7);
    endcase
  end

  // ID/EX register; flush takes priority over stall
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_rs_q      <= '0;
      r_op2_q     <= '0;
      r_dest_q    <= '0;
      r_link_q    <= 1'b0;
      r_link_pc_q <= '0;
      r_valid_q   <= 1'b0;
    end else if (!bus.stall) begin
      r_rs_q      <= w_rd_data[0];
      r_op2_q     <= bus.op2_imm ? w_imm : w_rd_data[1];
      r_dest_q    <= w_dest;
      r_link_q    <= bus.link;
      r_link_pc_q <= bus.next_pc;
      r_valid_q   <= bus.instr_valid;
    end
  end

  assign bus.rs_q      = r_rs_q;
  assign bus.op2_q     = r_op2_q;
  assign bus.dest_q    = r_dest_q;
  assign bus.link_q    = r_link_q;
  assign bus.link_pc_q = r_link_pc_q;
  assign bus.valid_q   = r_valid_q;
endmodule
